// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register; also returns multi-cycle accumulate state to execute. Optional flush port: EX_MEM_FLUSH_EN.
// Latency: 1 cycle ex_* -> mem_*; all outputs registered, no input-to-output combinational path.
// Backpressure: stall[3]/stall[4] select advance, bubble or hold; other stall bits are ignored.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
`ifdef EX_MEM_FLUSH_EN
    input  logic                flush,
`endif
    input  logic [5:0]          stall,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o
);

    logic [ADDR_W-1:0]   mem_wd_d,    mem_wd_q;
    logic                mem_wreg_d,  mem_wreg_q;
    logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
    logic                mem_whilo_d, mem_whilo_q;
    logic [DATA_W-1:0]   mem_hi_d,    mem_hi_q;
    logic [DATA_W-1:0]   mem_lo_d,    mem_lo_q;
    logic [2*DATA_W-1:0] hilo_d,      hilo_q;
    logic [CNT_W-1:0]    cnt_d,       cnt_q;

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;

        if (!stall[3] && !stall[4]) begin
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_whilo_d = ex_whilo;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            hilo_d      = '0;
            cnt_d       = '0;
        end else if (stall[3] && !stall[4]) begin
            // Bubble: write enables drop so memory/writeback see a no-op.
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
        end else if (stall[3] && stall[4]) begin
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
        end

`ifdef EX_MEM_FLUSH_EN
        if (flush) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_d      = '0;
            cnt_d       = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_whilo_q <= 1'b0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            hilo_q      <= '0;
            cnt_q       <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_whilo_q <= mem_whilo_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_whilo = mem_whilo_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios then randomized cycles against a reference model.
module tb_ex_mem_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
`ifdef EX_MEM_FLUSH_EN
    logic          flush = 1'b0;
`endif
    logic [5:0]    stall;
    logic [AW-1:0] ex_wd;
    logic          ex_wreg;
    logic [DW-1:0] ex_wdata;
    logic          ex_whilo;
    logic [DW-1:0] ex_hi;
    logic [DW-1:0] ex_lo;
    logic [2*DW-1:0] hilo_i;
    logic [CW-1:0] cnt_i;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic          mem_whilo;
    logic [DW-1:0] mem_hi;
    logic [DW-1:0] mem_lo;
    logic [2*DW-1:0] hilo_o;
    logic [CW-1:0] cnt_o;

    ex_mem_reg #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
`ifdef EX_MEM_FLUSH_EN
        .flush(flush),
`endif
        .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst)
            assert (!(stall[4] && !stall[3]))
            else $error("illegal stall vector %b (mem stalled while ex runs)", stall);
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: the expected contents after each edge.
    logic [AW-1:0]   m_wd;
    logic            m_wreg;
    logic [DW-1:0]   m_wdata;
    logic            m_whilo;
    logic [DW-1:0]   m_hi;
    logic [DW-1:0]   m_lo;
    logic [2*DW-1:0] m_hilo;
    logic [CW-1:0]   m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_wd = '0; m_wreg = 0; m_wdata = '0; m_whilo = 0;
        m_hi = '0; m_lo = '0; m_hilo = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        bit clear_all;
        clear_all = rst;
`ifdef EX_MEM_FLUSH_EN
        clear_all = clear_all || flush;
`endif
        if (clear_all) model_clear();
        else if (!stall[3] && !stall[4]) begin
            m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_whilo = ex_whilo;
            m_hi = ex_hi; m_lo = ex_lo; m_hilo = '0; m_cnt = '0;
        end else if (stall[3] && !stall[4]) begin
            m_wd = '0; m_wreg = 0; m_wdata = '0; m_whilo = 0; m_hi = '0; m_lo = '0;
            m_hilo = hilo_i; m_cnt = cnt_i;
        end else if (stall[3] && stall[4]) begin
            m_hilo = hilo_i; m_cnt = cnt_i;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("mem_wd", 64'(mem_wd), 64'(m_wd));
        check("mem_wreg", 64'(mem_wreg), 64'(m_wreg));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        check("mem_whilo", 64'(mem_whilo), 64'(m_whilo));
        check("mem_hi", 64'(mem_hi), 64'(m_hi));
        check("mem_lo", 64'(mem_lo), 64'(m_lo));
        check("hilo_o", hilo_o, m_hilo);
        check("cnt_o", 64'(cnt_o), 64'(m_cnt));
    endtask

    task automatic rand_ex();
        ex_wd = AW'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
        ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
        hilo_i = {$urandom, $urandom}; cnt_i = CW'($urandom);
    endtask

    initial begin
        model_clear();
        rst = 1; stall = '0;
        ex_wd = 5'd31; ex_wreg = 1; ex_wdata = 32'hFFFF_FFFF; ex_whilo = 1;
        ex_hi = 32'hAAAA_5555; ex_lo = 32'h5555_AAAA; hilo_i = '1; cnt_i = 2'd3;
        step();
        step();
        check("reset_wdata", 64'(mem_wdata), 64'd0);
        check("reset_hilo", hilo_o, 64'd0);

        // Pass-through
        rst = 0; stall = 6'b000000;
        ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'h0000_F0F0; ex_whilo = 0;
        ex_hi = 0; ex_lo = 0; hilo_i = 64'h55; cnt_i = 2'd2;
        step();
        check("pass_wd", 64'(mem_wd), 64'd3);
        check("pass_wdata", 64'(mem_wdata), 64'h0000_F0F0);
        check("pass_cnt", 64'(cnt_o), 64'd0);

        // Bubble
        stall = 6'b001111; ex_wreg = 1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1;
        hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        step();
        check("bubble_wreg", 64'(mem_wreg), 64'd0);
        check("bubble_whilo", 64'(mem_whilo), 64'd0);
        check("bubble_hilo", hilo_o, 64'h1_0000_0002);
        check("bubble_cnt", 64'(cnt_o), 64'd1);

        // Hold
        stall = 6'b000000; ex_wdata = 32'h1234_5678; ex_wreg = 1;
        step();
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom; cnt_i = CW'(i + 1); hilo_i = {$urandom, $urandom};
            step();
            check("hold_wdata", 64'(mem_wdata), 64'h1234_5678);
            check("hold_cnt", 64'(cnt_o), 64'(i + 1));
        end

        // Accumulate resume
        stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hA;
        step();
        check("acc_cnt1", 64'(cnt_o), 64'd1);
        check("acc_hilo1", hilo_o, 64'hA);
        stall = 6'b000000; cnt_i = 2'd2; ex_wdata = 32'hCAFE_0001; ex_wd = 5'd9;
        step();
        check("acc_cnt2", 64'(cnt_o), 64'd0);
        check("acc_hilo2", hilo_o, 64'd0);
        check("acc_wdata", 64'(mem_wdata), 64'hCAFE_0001);

`ifdef EX_MEM_FLUSH_EN
        stall = 6'b000000; ex_wreg = 1; ex_wdata = 32'h77;
        step();
        stall = 6'b011111; flush = 1;
        step();
        check("flush_wreg", 64'(mem_wreg), 64'd0);
        check("flush_wdata", 64'(mem_wdata), 64'd0);
        flush = 0; stall = 6'b000000;
        step();
        rst = 1; flush = 1;
        step();
        check("rstflush_wd", 64'(mem_wd), 64'd0);
        rst = 0; flush = 0;
`endif

        // Randomized: legal stall modes, occasional reset
        for (int i = 0; i < 400; i++) begin
            int mode;
            rand_ex();
            mode = int'($urandom_range(0, 2));
            stall = 6'($urandom);
            stall[3] = (mode != 0);
            stall[4] = (mode == 2);
            rst = ($urandom_range(0, 31) == 0);
`ifdef EX_MEM_FLUSH_EN
            flush = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute results: destination register address, write enable, write data, and HI/LO write request and values.
- Presents those results to the memory stage one cycle later.
- Under pipeline stall control it either holds its contents or inserts a bubble.
- It also carries the multi-cycle accumulate state (64-bit partial result plus step counter) back to execute, so a stalled multiply-accumulate resumes correctly.

Parameters:
- DATA_W, 32, general-purpose register / data width.
- ADDR_W, 5, register-file address width.
- CNT_W, 2, multi-cycle step counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1).
- stall  in  6  pipeline stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- ex_wd  in  ADDR_W  destination register address from execute.
- ex_wreg  in  1  destination-register write enable from execute.
- ex_wdata  in  DATA_W  result from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- ex_hi  in  DATA_W  HI value to write.
- ex_lo  in  DATA_W  LO value to write.
- hilo_i  in  2*DATA_W  partial accumulate result from execute.
- cnt_i  in  CNT_W  accumulate step index from execute.
- mem_wd  out  ADDR_W  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  DATA_W  registered ex_wdata.
- mem_whilo  out  1  registered ex_whilo.
- mem_hi  out  DATA_W  registered ex_hi.
- mem_lo  out  DATA_W  registered ex_lo.
- hilo_o  out  2*DATA_W  partial result returned to execute.
- cnt_o  out  CNT_W  step index returned to execute.

Behaviour:
- All outputs are registers; there is no combinational path from any input to any output.
- Reset: on a rising edge with rst=1, every output is set to 0 (mem_* zero, hilo_o = 0, cnt_o = 0). rst has top priority over all other inputs.
- Latency: 1 cycle from ex_* to mem_* when not stalled.
- The update mode is decided each cycle from stall[3] and stall[4]:
  - ADVANCE (stall[3]=0, stall[4]=0): mem_* <= ex_*; hilo_o <= 0; cnt_o <= 0.
  - BUBBLE (stall[3]=1, stall[4]=0): mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo <= 0; hilo_o <= hilo_i; cnt_o <= cnt_i.
  - HOLD (stall[3]=1, stall[4]=1): mem_* keep their previous values; hilo_o <= hilo_i; cnt_o <= cnt_i.
  - ILLEGAL (stall[3]=0, stall[4]=1): must never occur, because the stall vector is monotonic (a stalled stage stalls everything upstream). RTL holds all outputs. The bench flags this combination with an assertion.
- A bubble never asserts mem_wreg or mem_whilo, so no spurious register-file or HI/LO write can occur.
- hilo_o/cnt_o are meaningful only while execute is stalled. They are cleared on every ADVANCE so a new instruction always starts its accumulate at step 0.
- stall[0..2] and stall[5] are ignored.
- Reset mid-hold or mid-accumulate: the pending partial result and count are discarded and outputs return to 0 on that edge.
- No X propagation: every register has a defined value after the first reset edge.

Optional Feature:
- Macro EX_MEM_FLUSH_EN.
- When defined:
  - Adds an input port flush (1 bit).
  - flush=1 on a rising edge clears all outputs to 0, exactly like reset.
  - Priority is rst > flush > stall decode.
  - Used for exception flush; flush overrides HOLD.
- When undefined: no flush port, and behaviour is exactly as above.

Test Plan:
- Reset: drive all ex_* to nonzero and hold rst=1 for 2 cycles -> all outputs 0 on both edges.
- Pass-through: stall=6'b000000, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_F0F0 -> one edge later mem_wd=3, mem_wreg=1, mem_wdata=32'h0000_F0F0, hilo_o=0, cnt_o=0.
- Bubble: stall=6'b001111, ex_wreg=1, ex_wdata=32'hDEAD_BEEF, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_wreg=0, mem_wdata=0, mem_whilo=0, hilo_o=64'h1_0000_0002, cnt_o=1.
- Hold: load mem_wdata=32'h1234_5678, then stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata remains 32'h1234_5678 every cycle; cnt_o tracks cnt_i.
- Accumulate resume: cycle 1 stall=6'b001111, cnt_i=1, hilo_i=64'hA; cycle 2 stall=0, cnt_i=2 -> after cycle 1 cnt_o=1, hilo_o=64'hA; after cycle 2 cnt_o=0, hilo_o=0, mem_* = ex_*.
- With EX_MEM_FLUSH_EN: during HOLD (stall=6'b011111) with mem_wreg=1, pulse flush=1 for one cycle -> next edge all outputs 0; rst=1 with flush=1 -> all outputs 0.
